ikari_video_timing: RTL and testbench

- Raster timing generator for the Ikari Warriors core, running on the 53.6 MHz core clock.
- Consumes the 6.7 MHz pixel clock-enable from the core clock-enable generator.
- Produces the H/V counters, syncs, blanks, line/frame strobes and the vblank CPU interrupt request used by the tile/sprite renderers and the Z80 interrupt logic.
- Default geometry: 424x264 total, 288x216 active, 59.86 Hz.

---
 rtl/ikari_video_pkg.sv | 29 ++
 rtl/ikari_vblank_irq.sv | 42 ++++
 rtl/ikari_video_timing.sv | 163 ++++++++++++++++
 tb/tb_ikari_video_timing.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ikari_video_pkg.sv
// Shared geometry, counter width and IRQ state encoding for the Ikari video timing block.
package ikari_video_pkg;

  localparam int CNT_W = 9;
  localparam int POS_W = CNT_W + 1;

  localparam int H_TOTAL  = 424;
  localparam int H_ACTIVE = 288;
  localparam int HS_START = 320;
  localparam int HS_WIDTH = 32;
  localparam int V_TOTAL  = 264;
  localparam int V_ACTIVE = 216;
  localparam int VS_START = 236;
  localparam int VS_WIDTH = 8;
  localparam bit SYNC_POL = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } irq_state_t;

  // One extra bit of headroom so start+len never wraps for legal geometry.
  function automatic logic in_win(input logic [POS_W-1:0] pos,
                                  input logic [POS_W-1:0] start,
                                  input logic [POS_W-1:0] len);
    return (pos >= start) && (pos < start + len);
  endfunction

endpackage

// File: rtl/ikari_vblank_irq.sv
// Two-state interrupt request latch: set raises the request, ack clears it, set wins a tie.
module ikari_vblank_irq (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_set,
  input  logic i_ack,
  output logic o_irq
);
  import ikari_video_pkg::*;

  irq_state_t state_q;
  logic       irq_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_set) begin
            state_q <= PEND;
            irq_q   <= 1'b1;
          end
        end
        PEND: begin
          if (!i_set && i_ack) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_irq = irq_q;

endmodule

// File: rtl/ikari_video_timing.sv
// Raster timing generator: H/V counters, syncs, blanks, strobes, field and vblank IRQ.
// Optional sync position trim via IKARI_VIDEO_POS_ADJ_EN (i_hoffs/i_voffs ports).
module ikari_video_timing #(
  parameter int H_TOTAL  = ikari_video_pkg::H_TOTAL,
  parameter int H_ACTIVE = ikari_video_pkg::H_ACTIVE,
  parameter int HS_START = ikari_video_pkg::HS_START,
  parameter int HS_WIDTH = ikari_video_pkg::HS_WIDTH,
  parameter int V_TOTAL  = ikari_video_pkg::V_TOTAL,
  parameter int V_ACTIVE = ikari_video_pkg::V_ACTIVE,
  parameter int VS_START = ikari_video_pkg::VS_START,
  parameter int VS_WIDTH = ikari_video_pkg::VS_WIDTH,
  parameter bit SYNC_POL = ikari_video_pkg::SYNC_POL
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_pix_cen,
  input  logic                             i_irq_ack,
`ifdef IKARI_VIDEO_POS_ADJ_EN
  input  logic signed [3:0]                i_hoffs,
  input  logic signed [2:0]                i_voffs,
`endif
  output logic [ikari_video_pkg::CNT_W-1:0] o_hcount,
  output logic [ikari_video_pkg::CNT_W-1:0] o_vcount,
  output logic                             o_hsync,
  output logic                             o_vsync,
  output logic                             o_hblank,
  output logic                             o_vblank,
  output logic                             o_de,
  output logic                             o_line_start,
  output logic                             o_frame_start,
  output logic                             o_vblank_irq,
  output logic                             o_field
);
  import ikari_video_pkg::*;

  if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_geom_err
    $error("ikari_video_timing: H_TOTAL/V_TOTAL exceed the 9-bit counter range");
  end

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] HS_BASE = POS_W'(HS_START);
  localparam logic [POS_W-1:0] HS_LEN  = POS_W'(HS_WIDTH);
  localparam logic [POS_W-1:0] VS_BASE = POS_W'(VS_START);
  localparam logic [POS_W-1:0] VS_LEN  = POS_W'(VS_WIDTH);

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic hblank_q, hblank_d, vblank_q, vblank_d, de_q, de_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic field_q, field_d;
  logic h_wrap, v_wrap, frame_wrap, irq_set;

  assign h_wrap     = (hcount_q == H_LAST);
  assign v_wrap     = (vcount_q == V_LAST);
  assign frame_wrap = i_pix_cen & h_wrap & v_wrap;

  logic [POS_W-1:0] hs_start_d, vs_start_d;

`ifdef IKARI_VIDEO_POS_ADJ_EN
  logic [POS_W-1:0] hs_start_q, vs_start_q;

  // Offsets only latch on the frame wrap so a sync pulse is never cut mid-frame.
  always_comb begin
    hs_start_d = hs_start_q;
    vs_start_d = vs_start_q;
    if (frame_wrap) begin
      hs_start_d = HS_BASE + {{(POS_W-4){i_hoffs[3]}}, i_hoffs};
      vs_start_d = VS_BASE + {{(POS_W-3){i_voffs[2]}}, i_voffs};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hs_start_q <= HS_BASE;
      vs_start_q <= VS_BASE;
    end else begin
      hs_start_q <= hs_start_d;
      vs_start_q <= vs_start_d;
    end
  end
`else
  assign hs_start_d = HS_BASE;
  assign vs_start_d = VS_BASE;
`endif

  // Decodes are taken from the next count so they land with the count they describe.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    de_d          = de_q;
    field_d       = field_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    irq_set       = 1'b0;
    if (i_pix_cen) begin
      hcount_d = h_wrap ? '0 : hcount_q + CNT_W'(1);
      if (h_wrap) vcount_d = v_wrap ? '0 : vcount_q + CNT_W'(1);
      line_start_d  = h_wrap;
      frame_start_d = frame_wrap;
      field_d       = field_q ^ frame_wrap;
      hblank_d      = (hcount_d >= H_ACT);
      vblank_d      = (vcount_d >= V_ACT);
      de_d          = ~hblank_d & ~vblank_d;
      hsync_d       = in_win({1'b0, hcount_d}, hs_start_d, HS_LEN) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = in_win({1'b0, vcount_d}, vs_start_d, VS_LEN) ? SYNC_POL : ~SYNC_POL;
      irq_set       = h_wrap & (vcount_d == V_ACT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      field_q       <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      field_q       <= field_d;
    end
  end

  ikari_vblank_irq u_irq (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_set (irq_set),
    .i_ack (i_irq_ack),
    .o_irq (o_vblank_irq)
  );

  assign o_hcount      = hcount_q;
  assign o_vcount      = vcount_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_hblank      = hblank_q;
  assign o_vblank      = vblank_q;
  assign o_de          = de_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_field       = field_q;

endmodule

// File: tb/tb_ikari_video_timing.sv
// Scoreboard bench: default-geometry instance for line timing/reset, small-geometry instance for frame/IRQ.
module tb_ikari_video_timing;

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] v;
    logic hs, vs, hb, vb, de, ls, fs, irq, fld;
  } exp_t;

  typedef struct {
    int ht, ha, hss, hsw, vt, va, vss, vsw;
  } geo_t;

  typedef struct {
    int h, v;
    bit irq, fld;
  } mst_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_rst = 1'b1, i_pix_cen = 1'b0, i_irq_ack = 1'b0;

  logic [8:0] b_h, b_v, s_h, s_v;
  logic b_hs, b_vs, b_hb, b_vb, b_de, b_ls, b_fs, b_irq, b_fld;
  logic s_hs, s_vs, s_hb, s_vb, s_de, s_ls, s_fs, s_irq, s_fld;
  exp_t obs_b, obs_s;

  assign obs_b = {b_h, b_v, b_hs, b_vs, b_hb, b_vb, b_de, b_ls, b_fs, b_irq, b_fld};
  assign obs_s = {s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_de, s_ls, s_fs, s_irq, s_fld};

  ikari_video_timing u_big (
    .i_clk(clk), .i_rst(i_rst), .i_pix_cen(i_pix_cen), .i_irq_ack(i_irq_ack),
`ifdef IKARI_VIDEO_POS_ADJ_EN
    .i_hoffs(4'sd0), .i_voffs(3'sd0),
`endif
    .o_hcount(b_h), .o_vcount(b_v), .o_hsync(b_hs), .o_vsync(b_vs),
    .o_hblank(b_hb), .o_vblank(b_vb), .o_de(b_de), .o_line_start(b_ls),
    .o_frame_start(b_fs), .o_vblank_irq(b_irq), .o_field(b_fld)
  );

  ikari_video_timing #(
    .H_TOTAL(40), .H_ACTIVE(24), .HS_START(28), .HS_WIDTH(4),
    .V_TOTAL(30), .V_ACTIVE(20), .VS_START(23), .VS_WIDTH(3), .SYNC_POL(1'b0)
  ) u_small (
    .i_clk(clk), .i_rst(i_rst), .i_pix_cen(i_pix_cen), .i_irq_ack(i_irq_ack),
`ifdef IKARI_VIDEO_POS_ADJ_EN
    .i_hoffs(4'sd0), .i_voffs(3'sd0),
`endif
    .o_hcount(s_h), .o_vcount(s_v), .o_hsync(s_hs), .o_vsync(s_vs),
    .o_hblank(s_hb), .o_vblank(s_vb), .o_de(s_de), .o_line_start(s_ls),
    .o_frame_start(s_fs), .o_vblank_irq(s_irq), .o_field(s_fld)
  );

  geo_t gs[2];
  mst_t ms[2];
  exp_t q_b[$], q_s[$];
  int n_tot = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference raster model; outputs decoded from the model's own counts.
  function automatic exp_t mstep(int k, bit rst, bit cen, bit ack);
    exp_t e;
    bit hw, vw, set;
    e = '0;
    set = 1'b0;
    if (rst) begin
      ms[k].h = 0; ms[k].v = 0; ms[k].irq = 1'b0; ms[k].fld = 1'b0;
    end else begin
      if (cen) begin
        hw = (ms[k].h == gs[k].ht - 1);
        vw = (ms[k].v == gs[k].vt - 1);
        ms[k].h = hw ? 0 : ms[k].h + 1;
        if (hw) ms[k].v = vw ? 0 : ms[k].v + 1;
        e.ls = hw;
        e.fs = hw && vw;
        if (hw && vw) ms[k].fld = ~ms[k].fld;
        set = hw && (ms[k].v == gs[k].va);
      end
      if (set) ms[k].irq = 1'b1;
      else if (ack) ms[k].irq = 1'b0;
    end
    e.h   = 9'(ms[k].h);
    e.v   = 9'(ms[k].v);
    e.hs  = !(ms[k].h >= gs[k].hss && ms[k].h < gs[k].hss + gs[k].hsw);
    e.vs  = !(ms[k].v >= gs[k].vss && ms[k].v < gs[k].vss + gs[k].vsw);
    e.hb  = ms[k].h >= gs[k].ha;
    e.vb  = ms[k].v >= gs[k].va;
    e.de  = !e.hb && !e.vb;
    e.irq = ms[k].irq;
    e.fld = ms[k].fld;
    return e;
  endfunction

  task automatic tick(input bit rst, input bit cen, input bit ack);
    i_rst = rst; i_pix_cen = cen; i_irq_ack = ack;
    q_b.push_back(mstep(0, rst, cen, ack));
    q_s.push_back(mstep(1, rst, cen, ack));
    @(posedge clk);
    #1;
    chk("sb_big", 32'(obs_b), 32'(q_b.pop_front()));
    chk("sb_small", 32'(obs_s), 32'(q_s.pop_front()));
  endtask

  initial begin
    int hmax, ls_cnt, hs_lo, hs_first, hb_rise, n, vbr, vsl, vsf;
    bit prev_hb, prev_vb, f0;
    gs[0] = '{424, 288, 320, 32, 264, 216, 236, 8};
    gs[1] = '{40, 24, 28, 4, 30, 20, 23, 3};
    ms[0] = '{0, 0, 1'b0, 1'b0};
    ms[1] = '{0, 0, 1'b0, 1'b0};

    // reset with cen running
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    chk("rst_hv", {b_h, b_v}, 0);
    chk("rst_sync", {b_hs, b_vs}, 2'b11);
    chk("rst_irq_fld", {b_irq, b_fld}, 0);
    chk("rst_blank_de", {b_hb, b_vb, b_de}, 3'b001);

    // one line at cen every 8th clock
    hmax = 0; ls_cnt = 0; hs_lo = 0; hs_first = -1; hb_rise = -1; prev_hb = 1'b0;
    for (int c = 0; c < 8 * 425; c++) begin
      tick(1'b0, (c % 8) == 7, 1'b0);
      if (b_ls) begin
        ls_cnt++;
        chk("ls_at_wrap", b_h, 0);
      end
      if ((c % 8) == 7) begin
        if (int'(b_h) > hmax) hmax = int'(b_h);
        if (!b_hs) begin
          hs_lo++;
          if (hs_first < 0) hs_first = int'(b_h);
        end
        if (b_hb && !prev_hb) hb_rise = int'(b_h);
        prev_hb = b_hb;
      end
    end
    chk("h_max", hmax, 423);
    chk("ls_width", ls_cnt, 1);
    chk("hs_enables", hs_lo, 32);
    chk("hs_first", hs_first, 320);
    chk("hb_rise", hb_rise, 288);
    chk("line_v", b_v, 1);

    // full frame on the small instance, cen continuous
    for (n = 0; n < 3000 && !s_fs; n++) tick(1'b0, 1'b1, 1'b0);
    chk("reach_fs1", s_fs, 1);
    chk("irq_pend_fs1", s_irq, 1);
    f0 = s_fld;
    vbr = -1; vsl = 0; vsf = -1; prev_vb = s_vb;
    for (n = 1; n <= 1300; n++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (s_h == 0) begin
        if (!s_vs) begin
          vsl++;
          if (vsf < 0) vsf = int'(s_v);
        end
        if (s_vb && !prev_vb) vbr = int'(s_v);
        prev_vb = s_vb;
      end
      if (s_fs) break;
    end
    chk("frame_len", n, 40 * 30);
    chk("field_tog", s_fld, !f0);
    chk("vb_rise", vbr, 20);
    chk("vs_lines", vsl, 3);
    chk("vs_first", vsf, 23);

    // irq set/ack
    tick(1'b0, 1'b1, 1'b1);
    chk("irq_ack_clr", s_irq, 0);
    for (n = 0; n < 2000 && !s_irq; n++) tick(1'b0, 1'b1, 1'b0);
    chk("irq_rise_hv", {s_irq, s_h, s_v}, {1'b1, 9'd0, 9'd20});
    for (n = 0; n < 200 && s_v != 9'd22; n++) tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    chk("irq_ack_v22", s_irq, 0);
    for (n = 0; n < 2000 && !s_fs; n++) tick(1'b0, 1'b1, 1'b0);
    chk("irq_idle_fs", {s_fs, s_irq}, 2'b10);
    tick(1'b0, 1'b1, 1'b0);
    for (n = 0; n < 2000 && !s_fs; n++) tick(1'b0, 1'b1, 1'b0);
    chk("irq_stays_fs", {s_fs, s_irq}, 2'b11);

    // set and ack on the same cycle
    tick(1'b0, 1'b1, 1'b1);
    chk("irq_clr2", s_irq, 0);
    for (n = 0; n < 2000 && !(s_h == 9'd39 && s_v == 9'd19); n++) tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    chk("irq_set_wins", {s_irq, s_h, s_v}, {1'b1, 9'd0, 9'd20});
    tick(1'b0, 1'b0, 1'b1);
    chk("irq_ack_alone", s_irq, 0);

    // mid-frame reset and cen gating on the default instance
    for (n = 0; n < 60000 && !(b_h == 9'd100 && b_v == 9'd50); n++) tick(1'b0, 1'b1, 1'b0);
    chk("reach_100_50", {b_h, b_v}, {9'd100, 9'd50});
    tick(1'b1, 1'b0, 1'b0);
    chk("mid_rst_hv", {b_h, b_v}, 0);
    repeat (5) tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      chk("cen_hold_hv", {b_h, b_v}, {9'd5, 9'd0});
      chk("cen_strobes", {b_ls, b_fs, s_ls, s_fs}, 0);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
